// File: rtl/evt_seq_pkg.sv
// Shared state encoding and phase constants for the event sequence generator.
package evt_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PH_A   = 3'd1,
    PH_GAP = 3'd2,
    PH_B   = 3'd3,
    PH_F   = 3'd4,
    PH_G   = 3'd5,
    FIN    = 3'd6
  } state_t;

  localparam int unsigned NUM_PHASES = 5;

  // Phases are encoded consecutively from PH_A, so the last one sits at NUM_PHASES.
  localparam state_t LAST_PHASE = state_t'(NUM_PHASES);

endpackage

// File: rtl/evt_step_timer.sv
// Down-counter that times one phase: loaded with length-1, expires at zero.
module evt_step_timer #(
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load,
  input  logic [STEP_W-1:0] load_val,
  input  logic              en,
  output logic              expire
);

  logic [STEP_W-1:0] cnt;

  // Load wins over counting; the count holds at zero so it never wraps.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - STEP_W'(1);
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/evt_seq_gen.sv
// Event sequence generator: a pulse, gap, b, f (as b falls), f+g, then done.
// Optional macro EVT_SEQ_GEN_LOOP_EN adds a loop input that repeats passes.
module evt_seq_gen
  import evt_seq_pkg::*;
#(
  parameter int STEP_W   = 8,
  parameter int DEF_STEP = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic [STEP_W-1:0] step_len,
`ifdef EVT_SEQ_GEN_LOOP_EN
  input  logic              loop,
`endif
  output logic              busy,
  output logic              done,
  output logic              a,
  output logic              b,
  output logic              f,
  output logic              g
);

  localparam logic [STEP_W-1:0] DEF_LEN = STEP_W'(DEF_STEP);
  localparam logic [STEP_W-1:0] ONE     = STEP_W'(1);

  state_t            state, state_nxt;
  logic [STEP_W-1:0] len_q, len_nxt;
  logic [STEP_W-1:0] load_val;
  logic              load;
  logic              expire;
  logic              loop_req;

`ifdef EVT_SEQ_GEN_LOOP_EN
  assign loop_req = loop;
`else
  assign loop_req = 1'b0;
`endif

  function automatic logic is_phase(input state_t s);
    return (s inside {PH_A, PH_GAP, PH_B, PH_F, PH_G});
  endfunction

  evt_step_timer #(
    .STEP_W(STEP_W)
  ) u_timer (
    .clk     (clk),
    .rstn    (rstn),
    .load    (load),
    .load_val(load_val),
    .en      (is_phase(state)),
    .expire  (expire)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      len_q <= '0;
    end else begin
      state <= state_nxt;
      len_q <= len_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    len_nxt   = len_q;
    load      = 1'b0;
    load_val  = len_q - ONE;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nxt = PH_A;
            len_nxt   = (step_len == '0) ? DEF_LEN : step_len;
            load      = 1'b1;
            load_val  = len_nxt - ONE;
          end
        end
        FIN: state_nxt = IDLE;
        default: begin
          if (expire) begin
            if (state == LAST_PHASE) begin
              state_nxt = loop_req ? PH_A : FIN;
              load      = loop_req;
            end else begin
              state_nxt = state_t'(state + 3'd1);
              load      = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Outputs decode the next state so they switch on the same edge as the state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy <= 1'b0;
      done <= 1'b0;
      a    <= 1'b0;
      b    <= 1'b0;
      f    <= 1'b0;
      g    <= 1'b0;
    end else begin
      busy <= is_phase(state_nxt);
      done <= (state_nxt == FIN);
      a    <= (state_nxt == PH_A);
      b    <= (state_nxt == PH_B);
      f    <= (state_nxt == PH_F) || (state_nxt == PH_G);
      g    <= (state_nxt == PH_G);
    end
  end

endmodule

// File: tb/tb_evt_seq_gen.sv
// Bench for evt_seq_gen: cycle-level sequence model plus directed literal checks.
module tb_evt_seq_gen;

  localparam int STEP_W = 8;

  logic              clk = 1'b0;
  logic              rstn;
  logic              start;
  logic              abort;
  logic [STEP_W-1:0] step_len;
  logic              loop_sig;
  logic              busy, done, a, b, f, g;

  int total = 0;
  int bad   = 0;
  int cur   = 0;

  int m_active = 0;
  int m_k      = 0;
  int m_L      = 0;

  always #5 clk = ~clk;

  evt_seq_gen #(
    .STEP_W  (STEP_W),
    .DEF_STEP(5)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .abort   (abort),
    .step_len(step_len),
`ifdef EVT_SEQ_GEN_LOOP_EN
    .loop    (loop_sig),
`endif
    .busy    (busy),
    .done    (done),
    .a       (a),
    .b       (b),
    .f       (f),
    .g       (g)
  );

  // Model: k counts cycles since acceptance; phase = (k-1)/L, done at 5L+1.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_active <= 0;
      m_k      <= 0;
      m_L      <= 0;
    end else if (abort) begin
      m_active <= 0;
    end else if (m_active != 0) begin
      if (m_k == 5 * m_L + 1)                    m_active <= 0;
`ifdef EVT_SEQ_GEN_LOOP_EN
      else if (loop_sig && (m_k == 5 * m_L))     m_k <= 1;
`endif
      else                                       m_k <= m_k + 1;
    end else if (start) begin
      m_active <= 1;
      m_k      <= 1;
      m_L      <= (step_len == 0) ? 5 : int'(step_len);
    end
  end

  // Bit order {busy, done, a, b, f, g}.
  function automatic logic [5:0] exp_out(input int act, input int k, input int len);
    int ph;
    if (act == 0) return 6'b000000;
    if (k == 5 * len + 1) return 6'b010000;
    ph = (k - 1) / len;
    case (ph)
      0:       return 6'b101000;
      1:       return 6'b100000;
      2:       return 6'b100100;
      3:       return 6'b100010;
      default: return 6'b100011;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      total++;
      if ({busy, done, a, b, f, g} !== exp_out(m_active, m_k, m_L)) begin
        bad++;
        $display("FAIL model_cmp t=%0t got=%b want=%b", $time,
                 {busy, done, a, b, f, g}, exp_out(m_active, m_k, m_L));
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, got, want);
    end
  endtask

  task automatic at_cycle(input int n);
    while (cur < n) begin
      @(negedge clk);
      cur++;
    end
  endtask

  task automatic launch(input int len);
    step_len = STEP_W'(len);
    start    = 1'b1;
    cur      = 0;
    at_cycle(1);
    start    = 1'b0;
  endtask

  task automatic run_full(input int len, input int eff);
    launch(len);
    chk("run_a_on", a, 1);
    chk("run_busy_on", busy, 1);
    at_cycle(eff + 1);
    chk("run_gap", {a, b}, 0);
    at_cycle(2 * eff + 1);
    chk("run_b_on", b, 1);
    at_cycle(3 * eff + 1);
    chk("run_f_b", {f, b}, 2'b10);
    at_cycle(4 * eff + 1);
    chk("run_fg", {f, g}, 2'b11);
    at_cycle(5 * eff + 1);
    chk("run_done", {busy, done}, 2'b01);
    at_cycle(5 * eff + 2);
    chk("run_done_clr", {busy, done}, 2'b00);
    at_cycle(5 * eff + 4);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn     = 1'b0;
    start    = 1'b1;
    abort    = 1'b0;
    step_len = STEP_W'(5);
    loop_sig = 1'b0;

    repeat (3) begin
      @(negedge clk);
      chk("reset_outs", {busy, done, a, b, f, g}, 0);
    end
    rstn = 1'b1;
    cur  = 0;
    at_cycle(1);
    start = 1'b0;
    chk("post_reset_accept", {busy, a}, 2'b11);
    at_cycle(26);
    chk("post_reset_done", done, 1);
    at_cycle(28);

    run_full(5, 5);
    chk("basic_lit_idle", {busy, done, a, b, f, g}, 0);
    run_full(0, 5);
    run_full(1, 1);

    // Ignored start in PH_B, then abort in PH_F.
    launch(4);
    at_cycle(9);
    start = 1'b1;
    at_cycle(10);
    start = 1'b0;
    chk("ign_start_b", {busy, b}, 2'b11);
    at_cycle(13);
    chk("abort_pre_f", f, 1);
    abort = 1'b1;
    at_cycle(14);
    abort = 1'b0;
    chk("abort_outs", {busy, done, a, b, f, g}, 0);
    at_cycle(30);
    chk("abort_no_done", done, 0);

    // Start held high: one idle cycle between runs.
    step_len = STEP_W'(2);
    start    = 1'b1;
    cur      = 0;
    at_cycle(1);
    chk("held_a1", a, 1);
    at_cycle(11);
    chk("held_done", done, 1);
    at_cycle(12);
    chk("held_idle", {busy, done, a, b, f, g}, 0);
    at_cycle(13);
    chk("held_reaccept", {busy, a}, 2'b11);
    start = 1'b0;
    abort = 1'b1;
    at_cycle(14);
    abort = 1'b0;
    at_cycle(16);

    run_full(255, 255);

    // Asynchronous reset in PH_G.
    launch(3);
    at_cycle(14);
    chk("pre_arst_g", {f, g}, 2'b11);
    #2 rstn = 1'b0;
    #1 chk("arst_clear", {busy, done, a, b, f, g}, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_stay_idle", {busy, done}, 0);

`ifdef EVT_SEQ_GEN_LOOP_EN
    loop_sig = 1'b1;
    launch(2);
    at_cycle(11);
    chk("loop_a_again", {busy, a, done}, 3'b110);
    loop_sig = 1'b0;
    at_cycle(20);
    chk("loop_busy", busy, 1);
    at_cycle(21);
    chk("loop_single_done", done, 1);
    at_cycle(24);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
